// File: rtl/prio_encoder_seq_if.sv
// Handshake bundle for prio_encoder_seq: request side and result side.
// slave is the encoder's view, master is the producer/consumer view.
interface prio_encoder_seq_if #(
   parameter int WIDTH = 8
);
   localparam int CODE_W = $clog2(WIDTH);

   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  req_i;
   logic              out_valid;
   logic              out_ready;
   logic [CODE_W-1:0] out_code;
   logic              out_none;

   modport slave (
      input  in_valid,
      input  req_i,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_code,
      output out_none
   );

   modport master (
      output in_valid,
      output req_i,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_code,
      input  out_none
   );
endinterface

// File: rtl/prio_encoder_seq.sv
// Registered priority encoder with valid/ready on both sides.
// Define PRIO_ENC_RR_EN for rotating (round-robin) priority.
module prio_encoder_seq #(
   parameter  int WIDTH  = 8,
   localparam int CODE_W = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   prio_encoder_seq_if.slave    bus
);

   logic              out_valid_q;
   logic [CODE_W-1:0] out_code_q;
   logic              out_none_q;

   logic              accept;
   logic              pop;
   logic              any;
   logic              hi_any;
   logic [WIDTH-1:0]  upper;
   logic [CODE_W-1:0] win_lo;
   logic [CODE_W-1:0] win_hi;
   logic [CODE_W-1:0] win;

   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_code  = out_code_q;
   assign bus.out_none  = out_none_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign pop    = out_valid_q && bus.out_ready;
   assign any    = |bus.req_i;

`ifdef PRIO_ENC_RR_EN
   logic [CODE_W-1:0] ptr;

   // Bits at or above ptr are searched first; wrap falls back to all bits.
   always_comb begin
      upper = '0;
      for (int i = 0; i < WIDTH; i++) begin
         upper[i] = bus.req_i[i] && (CODE_W'(i) >= ptr);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept && any) begin
         if (win == CODE_W'(WIDTH - 1)) ptr <= '0;
         else                           ptr <= win + 1'b1;
      end
   end
`else
   assign upper = bus.req_i;
`endif

   assign hi_any = |upper;

   always_comb begin
      win_lo = '0;
      win_hi = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (bus.req_i[i]) win_lo = CODE_W'(i);
         if (upper[i])     win_hi = CODE_W'(i);
      end
   end

   assign win = hi_any ? win_hi : win_lo;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         out_none_q  <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_code_q  <= any ? win : '0;
         out_none_q  <= !any;
      end else if (pop) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Randomised self-checking bench for prio_encoder_seq (WIDTH=8).
// Reference model scans the vector with modulo arithmetic.
module tb_prio_encoder_seq;

   localparam int W = 8;

   logic clk;
   logic rst_n;

   prio_encoder_seq_if #(.WIDTH(W)) bus ();

   prio_encoder_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   bit       m_valid;
   int       m_code;
   bit       m_none;
   int       m_ptr;

   task automatic check(input string tag,
                        input int got,
                        input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0;
      m_code  = 0;
      m_none  = 0;
      m_ptr   = 0;
   endtask

   task automatic model_accept(input logic [W-1:0] r);
      int  idx;
      bit  found;
      m_valid = 1;
      if (r == '0) begin
         m_code = 0;
         m_none = 1;
      end else begin
         found = 0;
         for (int k = 0; k < W; k++) begin
            idx = (m_ptr + k) % W;
            if (!found && r[idx]) begin
               found  = 1;
               m_code = idx;
            end
         end
         m_none = 0;
`ifdef PRIO_ENC_RR_EN
         m_ptr = (m_code + 1) % W;
`endif
      end
   endtask

   task automatic check_out();
      check("out_valid", int'(bus.out_valid), int'(m_valid));
      check("out_code",  int'(bus.out_code),  m_code);
      check("out_none",  int'(bus.out_none),  int'(m_none));
   endtask

   task automatic step(input bit v,
                       input logic [W-1:0] r,
                       input bit ordy);
      bit acc;
      bit pop;
      @(negedge clk);
      check_out();
      bus.in_valid  = v;
      bus.req_i     = r;
      bus.out_ready = ordy;
      #1;
      check("in_ready", int'(bus.in_ready),
            int'(!m_valid || ordy));
      acc = v && (!m_valid || ordy);
      pop = m_valid && ordy;
      @(posedge clk);
      if (acc)      model_accept(r);
      else if (pop) m_valid = 0;
   endtask

   task automatic do_reset(input logic [W-1:0] r);
      @(negedge clk);
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.req_i     = r;
      bus.out_ready = 1'(($urandom & 1));
      @(posedge clk);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.req_i     = '0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      model_reset();
      do_reset(8'hFF);

      step(1, 8'b1010_1000, 1);
      step(1, 8'b1000_0000, 1);
      step(1, 8'b0000_0001, 1);
      step(1, 8'h00, 1);
      step(0, 8'h00, 1);

      step(1, 8'h10, 0);
      step(1, 8'h01, 0);
      step(1, 8'h01, 0);
      step(1, 8'h01, 0);
      step(1, 8'h01, 1);
      step(0, 8'h00, 1);

      step(1, 8'b0000_0101, 1);
      step(1, 8'b0000_0101, 1);
      step(1, 8'b0000_0101, 1);
      step(1, 8'h80, 1);
      step(1, 8'h81, 1);
      step(1, 8'h81, 1);
      step(0, 8'h00, 1);

      step(1, 8'h10, 0);
      do_reset(8'h42);
      step(1, 8'h21, 1);
      step(0, 8'h00, 1);

      for (int n = 0; n < 600; n++) begin
         logic [W-1:0] r;
         r = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
         if ($urandom_range(0, 99) == 0) do_reset(r);
         else step($urandom_range(0, 3) != 0, r,
                   $urandom_range(0, 9) < 7);
      end

      @(negedge clk);
      check_out();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
